// File: rtl/hsv_to_rgb.sv
// hsv_to_rgb
//   Three-stage pipelined decoder from the packed hue pixel format
//   {hue[8:0], sat[6:0], val[7:0]} to RGB888 {R, G, B}. A row/col sideband
//   travels with each pixel so downstream timing stays aligned.
//
// Ports
//   clk        pixel clock
//   rst        synchronous, active-high reset
//   en         1 = decode, 0 = bypass (sampled with the beat)
//   in_valid   pixel_in/side_in qualify this cycle
//   pixel_in   {hue[8:0], sat[6:0], val[7:0]}
//   side_in    sideband, delayed untouched
//   out_valid  pixel_out/side_out qualify this cycle (3 clocks after in_valid)
//   pixel_out  {R[7:0], G[7:0], B[7:0]}, holds when out_valid=0
//   side_out   side_in of the emerging beat, holds when out_valid=0
module hsv_to_rgb #(
    parameter int SIDE_W = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [23:0]       pixel_in,
    input  logic [SIDE_W-1:0] side_in,
    output logic              out_valid,
    output logic [23:0]       pixel_out,
    output logic [SIDE_W-1:0] side_out
);
    localparam int STAGES = 3;

    typedef struct packed {
        logic              en;
        logic [2:0]        sector;
        logic [5:0]        f;
        logic [7:0]        s;
        logic [7:0]        v;
        logic [23:0]       raw;
        logic [SIDE_W-1:0] side;
    } s1_t;

    typedef struct packed {
        logic              en;
        logic [2:0]        sector;
        logic [7:0]        v;
        logic [15:0]       a;
        logic [15:0]       b;
        logic [7:0]        p;
        logic [23:0]       raw;
        logic [SIDE_W-1:0] side;
    } s2_t;

    // valid bits shift every cycle regardless of data; a beat offered while
    // rst is high never enters the pipe
    logic [STAGES:1] vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    assign out_valid = vld_pipe[STAGES];

    // ---------------- stage 1: hue wrap, sector split, sat scaling
    logic [8:0] hue, h, base;
    logic [2:0] sector;
    logic [5:0] f;
    logic [7:0] s_scaled;
    s1_t        s1;

    assign hue = pixel_in[23:15];
    // single subtraction: 360..511 folds onto 0..151
    assign h   = (hue < 9'd360) ? hue : hue - 9'd360;

    always_comb begin
        sector = 3'd0;
        base   = 9'd0;
        if      (h < 9'd60)  begin sector = 3'd0; base = 9'd0;   end
        else if (h < 9'd120) begin sector = 3'd1; base = 9'd60;  end
        else if (h < 9'd180) begin sector = 3'd2; base = 9'd120; end
        else if (h < 9'd240) begin sector = 3'd3; base = 9'd180; end
        else if (h < 9'd300) begin sector = 3'd4; base = 9'd240; end
        else                 begin sector = 3'd5; base = 9'd300; end
    end

    assign f        = 6'(h - base);
    // sat=127 is treated as full scale so S spans exactly 0..128
    assign s_scaled = (pixel_in[14:8] == 7'd127) ? 8'd128 : {1'b0, pixel_in[14:8]};

    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1.en     <= en;
            s1.sector <= sector;
            s1.f      <= f;
            s1.s      <= s_scaled;
            s1.v      <= pixel_in[7:0];
            s1.raw    <= pixel_in;
            s1.side   <= side_in;
        end
    end

    // ---------------- stage 2: fractional hue to 0..250, S products
    logic [7:0]  ff;
    logic [15:0] a_nxt, b_nxt;
    s2_t         s2;

    assign ff    = 8'((10'(s1.f) * 10'd17) >> 2);
    assign a_nxt = 16'(s1.s) * {8'd0, ff};
    // peaks at exactly 32768 (S=128, ff=0), which still fits in 16 bits
    assign b_nxt = 16'(17'(s1.s) * (17'd256 - 17'(ff)));

    always_ff @(posedge clk) begin
        if (vld_pipe[1]) begin
            s2.en     <= s1.en;
            s2.sector <= s1.sector;
            s2.v      <= s1.v;
            s2.a      <= a_nxt;
            s2.b      <= b_nxt;
            s2.p      <= 8'd128 - s1.s;
            s2.raw    <= s1.raw;
            s2.side   <= s1.side;
        end
    end

    // ---------------- stage 3: p/q/t scaling by V and sector mux
    logic [7:0]  pp, qq, tt;
    logic [23:0] rgb;

    assign pp = 8'((16'(s2.v) * 16'(s2.p)) >> 7);
    assign qq = 8'((24'(s2.v) * (24'd32768 - 24'(s2.a))) >> 15);
    assign tt = 8'((24'(s2.v) * (24'd32768 - 24'(s2.b))) >> 15);

    always_comb begin
        rgb = 24'd0;
        case (s2.sector)
            3'd0:    rgb = {s2.v, tt,   pp  };
            3'd1:    rgb = {qq,   s2.v, pp  };
            3'd2:    rgb = {pp,   s2.v, tt  };
            3'd3:    rgb = {pp,   qq,   s2.v};
            3'd4:    rgb = {tt,   pp,   s2.v};
            3'd5:    rgb = {s2.v, pp,   qq  };
            default: rgb = 24'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out <= 24'd0;
            side_out  <= '0;
        end else if (vld_pipe[2]) begin
            pixel_out <= s2.en ? rgb : s2.raw;
            side_out  <= s2.side;
        end
    end
endmodule

// File: tb/tb_hsv_to_rgb.sv
module tb_hsv_to_rgb;
    localparam int SIDE_W = 26;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              in_valid;
    logic [23:0]       pixel_in;
    logic [SIDE_W-1:0] side_in;
    logic              out_valid;
    logic [23:0]       pixel_out;
    logic [SIDE_W-1:0] side_out;

    hsv_to_rgb #(.SIDE_W(SIDE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .pixel_in  (pixel_in),
        .side_in   (side_in),
        .out_valid (out_valid),
        .pixel_out (pixel_out),
        .side_out  (side_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                due;
        logic [23:0]       pix;
        logic [SIDE_W-1:0] side;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt = 0;
    bit   r_q = 1'b0;
    bit   started = 1'b0;
    logic [23:0]       last_pix;
    logic [SIDE_W-1:0] last_side;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cnt);
        end
    endtask

    // plain integer reading of the decode rules
    function automatic logic [23:0] ref_pix(input bit e, input logic [23:0] px);
        int hue, sat, v, h, sec, f, s, ff, a, b, pw, p, q, t, r, g, bl;
        if (!e) return px;
        hue = int'(px[23:15]);
        sat = int'(px[14:8]);
        v   = int'(px[7:0]);
        h   = (hue < 360) ? hue : hue - 360;
        sec = h / 60;
        f   = h - 60 * sec;
        s   = (sat == 127) ? 128 : sat;
        ff  = (f * 17) / 4;
        a   = s * ff;
        b   = s * (256 - ff);
        pw  = 128 - s;
        p   = (v * pw) / 128;
        q   = (v * (32768 - a)) / 32768;
        t   = (v * (32768 - b)) / 32768;
        case (sec)
            0: begin r = v; g = t; bl = p; end
            1: begin r = q; g = v; bl = p; end
            2: begin r = p; g = v; bl = t; end
            3: begin r = p; g = q; bl = v; end
            4: begin r = t; g = p; bl = v; end
            default: begin r = v; g = p; bl = q; end
        endcase
        return {8'(r), 8'(g), 8'(bl)};
    endfunction

    always @(posedge clk) begin
        r_q = rst;
        cnt++;
    end

    // outputs are compared every cycle: valid timing, data on valid beats,
    // and held values (or reset zeros) on idle cycles
    always @(negedge clk) begin
        if (started) begin
            bit   exp_v;
            exp_t e;
            exp_v = (sb.size() > 0) && (sb[0].due == cnt);
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            if (r_q) begin
                last_pix  = '0;
                last_side = '0;
            end
            if (exp_v) begin
                e = sb.pop_front();
                last_pix  = e.pix;
                last_side = e.side;
            end
            chk("pixel_out", {8'd0, pixel_out}, {8'd0, last_pix});
            chk("side_out", {6'd0, side_out}, {6'd0, last_side});
        end
    end

    task automatic drive(input bit v, input bit e, input logic [23:0] px,
                         input logic [SIDE_W-1:0] sd, input bit use_k, input logic [23:0] k);
        exp_t x;
        @(posedge clk);
        #1;
        in_valid = v;
        en       = e;
        pixel_in = px;
        side_in  = sd;
        if (v && !rst) begin
            x.due  = cnt + 3;
            x.pix  = use_k ? k : ref_pix(e, px);
            x.side = sd;
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, 24'd0, '0, 1'b0, 24'd0);
    endtask

    // reset with a beat offered alongside it; anything not yet emerged is lost
    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        pixel_in = 24'h123456;
        side_in  = SIDE_W'(26'h2aaaaaa);
        while (sb.size() > 0 && sb[$].due > cnt) void'(sb.pop_back());
        repeat (n - 1) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    function automatic logic [23:0] hsv(input int h, input int s, input int v);
        return {9'(h), 7'(s), 8'(v)};
    endfunction

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; pixel_in = '0; side_in = '0;
        last_pix = '0; last_side = '0;
        @(posedge clk);
        #1;
        started = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // primaries, secondaries, midpoint, wrap, grey, black
        drive(1, 1, hsv(0,   127, 255), 26'h0000001, 1, 24'hFF0000);
        drive(1, 1, hsv(120, 127, 255), 26'h0002002, 1, 24'h00FF00);
        drive(1, 1, hsv(240, 127, 255), 26'h0004003, 1, 24'h0000FF);
        drive(1, 1, hsv(60,  127, 255), 26'h0006004, 1, 24'hFFFF00);
        drive(1, 1, hsv(300, 127, 255), 26'h0008005, 1, 24'hFF00FF);
        drive(1, 1, hsv(30,  127, 255), 26'h000a006, 1, 24'hFF7E00);
        drive(1, 1, hsv(360, 127, 255), 26'h000c007, 1, 24'hFF0000);
        drive(1, 1, hsv(359, 127, 255), 26'h000e008, 1, 24'hFF0005);
        drive(1, 1, hsv(511, 127, 255), 26'h0010009, 1, 24'h00FF82);
        drive(1, 1, hsv(200, 0,   128), 26'h001200a, 1, 24'h808080);
        drive(1, 1, hsv(470, 0,   128), 26'h001400b, 1, 24'h808080);
        drive(1, 1, hsv(100, 50,  0),   26'h001600c, 1, 24'h000000);
        idle(4);

        // en toggling beat by beat, back to back
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) drive(1, 1, 24'h00FFFF, SIDE_W'(i), 0, 24'd0);
            else            drive(1, 0, 24'h00FFFF, SIDE_W'(i), 1, 24'h00FFFF);
        end
        idle(4);

        // bubble pattern 1,0,1,1
        drive(1, 1, 24'($urandom), SIDE_W'($urandom), 0, 24'd0);
        drive(0, 1, 24'($urandom), SIDE_W'($urandom), 0, 24'd0);
        drive(1, 1, 24'($urandom), SIDE_W'($urandom), 0, 24'd0);
        drive(1, 0, 24'($urandom), SIDE_W'($urandom), 0, 24'd0);
        idle(5);

        // reset with two beats in flight, then a fresh beat
        drive(1, 1, hsv(10, 90, 200), 26'h3ffffff, 0, 24'd0);
        drive(1, 1, hsv(20, 90, 200), 26'h3fffffe, 0, 24'd0);
        do_reset(2);
        idle(4);
        drive(1, 1, hsv(180, 127, 255), 26'h0abcdef, 1, 24'h00FFFF);
        idle(5);

        // random sweep
        for (int n = 0; n < 10000; ) begin
            bit v;
            v = ($urandom_range(0, 9) < 8);
            drive(v, ($urandom_range(0, 9) != 0), 24'($urandom), SIDE_W'($urandom), 0, 24'd0);
            if (v) n++;
        end
        idle(6);
        chk("drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
